gray_counter: RTL and testbench
===============================

Name: gray_counter

Overview:
- Registered binary-to-Gray pointer generator: counts in binary internally and presents the Gray-coded value of the count from a flop.
- Forward-direction companion to the team's Gray-to-binary converter. Its Gray output is the value that converter decodes.
- Intended for async-FIFO read/write pointers and clock-domain-crossing counters. There the Gray output must change exactly one bit per step and must be glitch-free, so it is driven straight from a flop.

Parameters:
- WIDTH, 4, count width in bits (>=2); count range 0 .. 2^WIDTH-1, modulo 2^WIDTH.
- RST_VAL, 0, binary value loaded on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; advance one step this cycle.
- up  input  1  direction when en=1: 1 = increment, 0 = decrement.
- load  input  1  synchronous load of load_bin; overrides en.
- load_bin  input  WIDTH  binary value to load.
- bin_q  output  WIDTH  registered binary count.
- gray_q  output  WIDTH  registered Gray code of bin_q; gray_q == bin_q ^ (bin_q >> 1) at all times.
- gray_next  output  WIDTH  combinational Gray code of the value bin_q takes at the next edge (for look-ahead full/empty compares).
- wrap  output  1  registered one-cycle pulse: last step crossed the modulo boundary.
- busy_step  output  1  registered; 1 when the last edge changed the count via en (not load).

Behaviour:
- Reset (rst_n=0, asynchronous, immediate):
  - bin_q=RST_VAL and gray_q=RST_VAL^(RST_VAL>>1).
  - wrap=0 and busy_step=0.
  - Deassertion takes effect at the first clk edge after rst_n=1.
- Next-state bin_n, with priority load > en > hold:
  - load=1: bin_n=load_bin. Ignore en/up.
  - en=1, up=1: bin_n=bin_q+1 mod 2^WIDTH.
  - en=1, up=0: bin_n=bin_q-1 mod 2^WIDTH.
  - Otherwise: bin_n=bin_q.
- Registers on each rising edge:
  - bin_q<=bin_n.
  - gray_q<=bin_n^(bin_n>>1). Gray is computed from bin_n, not from bin_q, so gray_q and bin_q update in the same cycle with zero relative latency.
- gray_next = bin_n^(bin_n>>1). Purely combinational from the current inputs and bin_q.
- wrap<=1 for exactly the cycle after either:
  - an en step up from all-ones to 0, or
  - an en step down from 0 to all-ones.
  - Otherwise wrap<=0. Load never sets wrap, even if it moves the count across the boundary.
- busy_step<=1 if (en & ~load), else 0.
- Single-bit property: every en step changes gray_q in exactly one bit, including at wrap-around. A load may change any number of bits.
- Simultaneous load and en: load wins; wrap=0; busy_step=0.
- Hold (en=0, load=0): all registers keep their values; wrap and busy_step drop to 0.
- Reset mid-count: outputs return to reset values immediately, regardless of the clock.
- Direction change between consecutive steps is legal and has no penalty cycle.
- No X propagation: outputs are defined from reset onward.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with RST_VAL=0 -> bin_q=0000, gray_q=0000, wrap=0, without waiting for clk.
- Up sweep, WIDTH=4: en=1, up=1 for 16 cycles from 0.
  - Sequence: gray_q follows 0000,0001,0011,0010,0110,…,1000, then 0000.
  - Exactly one gray bit changes per cycle.
  - wrap=1 only on the cycle after 1111->0000.
  - Feeding gray_q through the Gray-to-binary converter returns bin_q on every cycle.
- Down wrap: load_bin=0001 with load=1, then en=1, up=0 for 2 cycles -> bin_q 0001, 0000, 1111; gray_q 0001, 0000, 1000; wrap=1 after the 0000->1111 step.
- Load priority: bin_q=0101, load=1 with load_bin=1110 and en=1, up=1 -> bin_q=1110, gray_q=1001, wrap=0, busy_step=0.
- Hold and look-ahead: bin_q=0111 with en=0, load=0 -> gray_next=0100 and unchanged over 3 cycles. Then raise en=1, up=1 -> gray_next=1100 in that cycle and gray_q=1100 after the edge.
- Direction flip: from bin_q=0011, up=1 then up=0 on consecutive cycles with en=1 -> bin_q 0100 then 0011; gray_q 0110 then 0010; busy_step=1 both cycles.

Source files
------------

// File: rtl/gray_counter.sv
// ---------------------------------------------------------------------------
// gray_counter : binary up/down counter with registered Gray-coded output
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gray_counter #(
  parameter int                 WIDTH   = 4,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic [WIDTH-1:0] gray_next,
  output logic             wrap,
  output logic             busy_step
);

  localparam logic [WIDTH-1:0] C_ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_ZERO     = '0;
  localparam logic [WIDTH-1:0] C_ALL_ONES = '1;
  localparam logic [WIDTH-1:0] C_RST_GRAY = RST_VAL ^ (RST_VAL >> 1);

  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             wrap_d;
  logic             wrap_q;
  logic             busy_step_d;
  logic             busy_step_q;

  // Next binary value: load beats en, en beats hold.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (up) begin
        bin_d  = bin_q + C_ONE;
        wrap_d = (bin_q == C_ALL_ONES);
      end else begin
        bin_d  = bin_q - C_ONE;
        wrap_d = (bin_q == C_ZERO);
      end
    end
  end

  // Gray is encoded from the next binary value so both registers update together.
  always_comb begin
    gray_d      = bin_d ^ (bin_d >> 1);
    busy_step_d = en & ~load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q       <= RST_VAL;
      gray_q      <= C_RST_GRAY;
      wrap_q      <= 1'b0;
      busy_step_q <= 1'b0;
    end else begin
      bin_q       <= bin_d;
      gray_q      <= gray_d;
      wrap_q      <= wrap_d;
      busy_step_q <= busy_step_d;
    end
  end

  assign gray_next = gray_d;
  assign wrap      = wrap_q;
  assign busy_step = busy_step_q;

endmodule

`default_nettype wire

// File: tb/tb_gray_counter.sv
// ---------------------------------------------------------------------------
// tb_gray_counter : directed scoreboard bench for gray_counter (WIDTH=4)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gray_counter;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] gray_next;
  logic             wrap;
  logic             busy_step;

  gray_counter #(.WIDTH(WIDTH), .RST_VAL(4'b0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_bin  (load_bin),
    .bin_q     (bin_q),
    .gray_q    (gray_q),
    .gray_next (gray_next),
    .wrap      (wrap),
    .busy_step (busy_step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] gray;
    logic             wrap;
    logic             busy;
    logic             onebit;
    string            name;
  } exp_t;

  exp_t             sb[$];
  exp_t             m_e;
  logic [WIDTH-1:0] prev_gray;
  int               n_cmp = 0;
  int               n_bad = 0;

  // Sweep Gray values after steps 1..16 starting from 0.
  logic [WIDTH-1:0] gseq [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                  4'b0111, 4'b0101, 4'b0100, 4'b1100,
                                  4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                  4'b1011, 4'b1001, 4'b1000, 4'b0000};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic step(input logic ld, input logic [WIDTH-1:0] lb, input logic e,
                      input logic u, input logic [WIDTH-1:0] eb, input logic [WIDTH-1:0] eg,
                      input logic ew, input logic ebusy, input string nm);
    exp_t x;
    @(negedge clk);
    load     = ld;
    load_bin = lb;
    en       = e;
    up       = u;
    x.bin    = eb;
    x.gray   = eg;
    x.wrap   = ew;
    x.busy   = ebusy;
    x.onebit = e & ~ld;
    x.name   = nm;
    sb.push_back(x);
    #1 chk({nm, " gray_next"}, 32'(gray_next), 32'(eg));
  endtask

  // Monitor: every clock produces an output sample; compare against the queue head.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      m_e = sb.pop_front();
      chk({m_e.name, " bin_q"},     32'(bin_q),     32'(m_e.bin));
      chk({m_e.name, " gray_q"},    32'(gray_q),    32'(m_e.gray));
      chk({m_e.name, " wrap"},      32'(wrap),      32'(m_e.wrap));
      chk({m_e.name, " busy_step"}, 32'(busy_step), 32'(m_e.busy));
      chk({m_e.name, " g2b"},       32'(g2b(gray_q)), 32'(m_e.bin));
      if (m_e.onebit)
        chk({m_e.name, " onebit"}, 32'($countones(gray_q ^ prev_gray)), 32'd1);
    end
    prev_gray = gray_q;
  end

  task automatic drain();
    int budget;
    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #2;
    chk("drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_bin = '0;
    prev_gray = '0;
    #12;
    chk("reset bin_q", 32'(bin_q), 32'h0);
    chk("reset gray_q", 32'(gray_q), 32'h0);
    chk("reset wrap", 32'(wrap), 32'h0);
    chk("reset busy", 32'(busy_step), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Up sweep through the full range; wrap only after 1111 -> 0000.
    for (int i = 0; i < 16; i++)
      step(1'b0, 4'h0, 1'b1, 1'b1, 4'((i + 1) % 16), gseq[i], (i == 15), 1'b1,
           $sformatf("sweep%0d", i));

    // Down wrap from 0001.
    step(1'b1, 4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0, "dn_load");
    step(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, "dn_step1");
    step(1'b0, 4'b0000, 1'b1, 1'b0, 4'b1111, 4'b1000, 1'b1, 1'b1, "dn_wrap");

    // Load priority over en, and load across the boundary never wraps.
    step(1'b1, 4'b0101, 1'b0, 1'b0, 4'b0101, 4'b0111, 1'b0, 1'b0, "lp_load");
    step(1'b1, 4'b1110, 1'b1, 1'b1, 4'b1110, 4'b1001, 1'b0, 1'b0, "lp_prio");
    step(1'b1, 4'b1111, 1'b0, 1'b0, 4'b1111, 4'b1000, 1'b0, 1'b0, "lp_ff");
    step(1'b1, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, "lp_nowrap");

    // Hold with look-ahead, then a single up step.
    step(1'b1, 4'b0111, 1'b0, 1'b0, 4'b0111, 4'b0100, 1'b0, 1'b0, "hold_load");
    for (int i = 0; i < 3; i++)
      step(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0111, 4'b0100, 1'b0, 1'b0,
           $sformatf("hold%0d", i));
    step(1'b0, 4'b0000, 1'b1, 1'b1, 4'b1000, 4'b1100, 1'b0, 1'b1, "hold_up");

    // Direction flip on consecutive cycles.
    step(1'b1, 4'b0011, 1'b0, 1'b0, 4'b0011, 4'b0010, 1'b0, 1'b0, "flip_load");
    step(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0100, 4'b0110, 1'b0, 1'b1, "flip_up");
    step(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0011, 4'b0010, 1'b0, 1'b1, "flip_dn");
    step(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0100, 4'b0110, 1'b0, 1'b1, "flip_up2");
    drain();

    // Asynchronous reset mid-cycle with en still active.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async bin_q", 32'(bin_q), 32'h0);
    chk("async gray_q", 32'(gray_q), 32'h0);
    chk("async wrap", 32'(wrap), 32'h0);
    chk("async busy", 32'(busy_step), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold bin_q", 32'(bin_q), 32'h0);
    chk("rst_hold busy", 32'(busy_step), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;
    step(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0001, 4'b0001, 1'b0, 1'b1, "post_rst");
    step(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0, "post_hold");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
